// File: rtl/harris_corner_ctrl.sv
// harris_corner_ctrl: frame sequencer, feature threshold and corner FIFO for the Harris datapath.
// Define HARRIS_ROI_EN to add a per-frame region of interest on reported corners.
module harris_corner_ctrl #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int FEAT_W     = 54
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [7:0]        scale_in,
    input  logic [FEAT_W-1:0] threshold,
    input  logic [FEAT_W-1:0] harris_feature,
`ifdef HARRIS_ROI_EN
    input  logic [9:0]        roi_x0,
    input  logic [9:0]        roi_x1,
    input  logic [8:0]        roi_y0,
    input  logic [8:0]        roi_y1,
`endif
    output logic              clk_en,
    output logic [7:0]        scale,
    output logic              corner_valid,
    input  logic              corner_ready,
    output logic [9:0]        corner_x,
    output logic [8:0]        corner_y,
    output logic [15:0]       corner_count,
    output logic              overflow,
    output logic              frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    state_t            state;
    logic [9:0]        x;
    logic [8:0]        y;
    logic [3:0]        dcnt;
    logic [FEAT_W-1:0] thr;
    logic [LAT-1:0]    dv;
    logic [9:0]        dx [LAT];
    logic [8:0]        dy [LAT];
    logic [18:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wp, rp;
    logic [AW:0]       occ;
    logic              acc, last_x, last_y, qual, roi_ok, detect, full, pop, push;
`ifdef HARRIS_ROI_EN
    logic [9:0]        rx0, rx1;
    logic [8:0]        ry0, ry1;
    assign roi_ok = dx[LAT-1] >= rx0 && dx[LAT-1] <= rx1 && dy[LAT-1] >= ry0 && dy[LAT-1] <= ry1;
`else
    assign roi_ok = 1'b1;
`endif
    assign clk_en       = pix_valid && state == RUN;
    assign acc          = clk_en && !frame_start;
    assign last_x       = x == 10'(H_ACTIVE - 1);
    assign last_y       = y == 9'(V_ACTIVE - 1);
    assign qual         = x >= 10'd4 && y >= 9'd4;
    assign detect       = dv[LAT-1] && $signed(harris_feature) > $signed(thr) && roi_ok;
    assign full         = occ == (AW+1)'(FIFO_DEPTH);
    assign corner_valid = occ != '0;
    assign pop          = corner_valid && corner_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push         = detect && (!full || pop);
    assign {corner_x, corner_y} = mem[rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            x            <= '0;
            y            <= '0;
            dcnt         <= '0;
            thr          <= '0;
            scale        <= '0;
            corner_count <= '0;
            overflow     <= 1'b0;
            frame_done   <= 1'b0;
            dv           <= '0;
            wp           <= '0;
            rp           <= '0;
            occ          <= '0;
            for (int i = 0; i < LAT; i++) begin
                dx[i] <= '0;
                dy[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
`ifdef HARRIS_ROI_EN
            rx0 <= '0;
            rx1 <= '0;
            ry0 <= '0;
            ry1 <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            dv         <= LAT'({dv, acc && qual});
            dx[0]      <= x - 10'd2;
            dy[0]      <= y - 9'd2;
            for (int i = 1; i < LAT; i++) begin
                dx[i] <= dx[i-1];
                dy[i] <= dy[i-1];
            end
            if (frame_start) begin
                corner_count <= '0;
                overflow     <= 1'b0;
            end else if (detect) begin
                if (corner_count != 16'hFFFF) corner_count <= corner_count + 16'd1;
                if (!push) overflow <= 1'b1;
            end
            if (push) begin
                mem[wp] <= {dx[LAT-1], dy[LAT-1]};
                wp      <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
            if (frame_start) begin
                state <= RUN;
                x     <= '0;
                y     <= '0;
                dcnt  <= '0;
                scale <= scale_in;
                thr   <= threshold;
`ifdef HARRIS_ROI_EN
                rx0 <= roi_x0;
                rx1 <= roi_x1;
                ry0 <= roi_y0;
                ry1 <= roi_y1;
`endif
            end else if (state == RUN && pix_valid) begin
                x <= last_x ? 10'd0 : x + 10'd1;
                y <= last_x ? (last_y ? 9'd0 : y + 9'd1) : y;
                if (last_x && last_y) begin
                    state <= DRAIN;
                    dcnt  <= '0;
                end
            end else if (state == DRAIN) begin
                if (dcnt == 4'(LAT)) begin
                    state      <= IDLE;
                    frame_done <= 1'b1;
                end else begin
                    dcnt <= dcnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_harris_corner_ctrl.sv
// tb_harris_corner_ctrl: directed frame vectors and corner-case sequences on an 8x6 raster.
module tb_harris_corner_ctrl;
    localparam int H = 8, V = 6, LAT = 3, DEPTH = 4, FW = 54;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0, pix_valid = 1'b0, corner_ready = 1'b0;
    logic [7:0]    scale_in = '0;
    logic [FW-1:0] threshold = '0, harris_feature = '0;
    logic          clk_en, corner_valid, overflow, frame_done;
    logic [7:0]    scale;
    logic [9:0]    corner_x;
    logic [8:0]    corner_y;
    logic [15:0]   corner_count;
`ifdef HARRIS_ROI_EN
    logic [9:0]    roi_x0 = 10'd0, roi_x1 = 10'd1023;
    logic [8:0]    roi_y0 = 9'd0, roi_y1 = 9'd511;
`endif
    int n_cmp = 0, n_bad = 0, fd_pulses = 0;
    int exp_x[$], exp_y[$];

    typedef struct {
        longint thr;
        longint feat;
        bit     rdy;
        int     cnt;
        bit     ovf;
        int     nq;
    } vec_t;
    vec_t vecs[7];

    always #5 clk = ~clk;
    always @(negedge clk) if (frame_done) fd_pulses++;

    harris_corner_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .LAT(LAT), .FIFO_DEPTH(DEPTH), .FEAT_W(FW)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pix_valid(pix_valid),
        .scale_in(scale_in), .threshold(threshold), .harris_feature(harris_feature),
`ifdef HARRIS_ROI_EN
        .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
`endif
        .clk_en(clk_en), .scale(scale), .corner_valid(corner_valid), .corner_ready(corner_ready),
        .corner_x(corner_x), .corner_y(corner_y), .corner_count(corner_count),
        .overflow(overflow), .frame_done(frame_done)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_frame(input longint thr, input logic [7:0] s);
        frame_start = 1'b1;
        threshold   = FW'(thr);
        scale_in    = s;
        pix_valid   = 1'b0;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic run_pixels(input int n);
        pix_valid = 1'b1;
        repeat (n) tick();
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int at = -1;
        for (int k = 0; k < 8; k++) begin
            if (frame_done && at < 0) at = k;
            tick();
        end
        check({name, "_done_lat"}, at, LAT + 1);
    endtask

    task automatic set_exp_row(input int x0, input int n, input int yy);
        exp_x.delete();
        exp_y.delete();
        for (int i = 0; i < n; i++) begin
            exp_x.push_back(x0 + i);
            exp_y.push_back(yy);
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        corner_ready = 1'b1;
        while (corner_valid && k < DEPTH + 2) begin
            if (k < exp_x.size()) begin
                check($sformatf("%s_x%0d", name, k), corner_x, exp_x[k]);
                check($sformatf("%s_y%0d", name, k), corner_y, exp_y[k]);
            end
            k++;
            tick();
        end
        corner_ready = 1'b0;
        check({name, "_nq"}, k, exp_x.size());
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0;
        vecs[0] = '{100, 101, 0, 8, 1, 4};
        vecs[1] = '{100, 100, 0, 0, 0, 0};
        vecs[2] = '{-5, -4, 0, 8, 1, 4};
        vecs[3] = '{-5, -6, 0, 0, 0, 0};
        vecs[4] = '{0, 1, 1, 8, 0, 0};
        vecs[5] = '{(64'sd1 <<< 53) - 1, -1, 0, 0, 0, 0};
        vecs[6] = '{-(64'sd1 <<< 53), (64'sd1 <<< 53) - 1, 0, 8, 1, 4};

        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("rst_clk_en", clk_en, 0);
        check("rst_valid", corner_valid, 0);
        check("rst_count", corner_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_scale", scale, 0);

        // Reset in the middle of a frame that already has corners queued
        harris_feature = 101;
        start_frame(100, 8'h5A);
        run_pixels(41);
        repeat (3) tick();
        check("mid_count", corner_count, 4);
        check("mid_valid", corner_valid, 1);
        check("mid_scale", scale, 8'h5A);
        pix_valid = 1'b1;
        reset = 1'b1;
        #1;
        check("arst_clk_en", clk_en, 0);
        check("arst_valid", corner_valid, 0);
        check("arst_count", corner_count, 0);
        check("arst_scale", scale, 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_clk_en%0d", i), clk_en, 0);
            tick();
        end
        pix_valid = 1'b0;
        check("idle_no_done", fd_pulses, 0);

        for (int i = 0; i < 7; i++) begin
            fd0 = fd_pulses;
            harris_feature = FW'(vecs[i].feat);
            corner_ready = vecs[i].rdy;
            start_frame(vecs[i].thr, 8'(i * 17 + 3));
            run_pixels(H * V);
            wait_done($sformatf("v%0d", i));
            check($sformatf("v%0d_count", i), corner_count, vecs[i].cnt);
            check($sformatf("v%0d_ovf", i), overflow, vecs[i].ovf);
            check($sformatf("v%0d_scale", i), scale, i * 17 + 3);
            check($sformatf("v%0d_pulses", i), fd_pulses - fd0, 1);
            set_exp_row(2, vecs[i].nq, 2);
            drain($sformatf("v%0d", i));
        end

        // Full FIFO with the consumer ready on a detect cycle
        harris_feature = 101;
        corner_ready = 1'b0;
        start_frame(100, 8'h01);
        pix_valid = 1'b1;
        for (int p = 0; p < H * V; p++) begin
            corner_ready = (p == H * V - 1);
            tick();
        end
        pix_valid = 1'b0;
        corner_ready = 1'b0;
        harris_feature = 100;
        wait_done("full");
        check("full_count", corner_count, 5);
        check("full_ovf", overflow, 0);
        set_exp_row(3, 3, 2);
        exp_x.push_back(2);
        exp_y.push_back(3);
        drain("full");

        // Aborted frames: counters restart, FIFO survives, no frame_done
        fd0 = fd_pulses;
        harris_feature = 101;
        start_frame(100, 8'h11);
        run_pixels(43);
        check("abort_pre_count", corner_count, 4);
        frame_start = 1'b1;
        scale_in = 8'h22;
        pix_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort1_count", corner_count, 0);
        check("abort1_scale", scale, 8'h22);
        run_pixels(19);
        frame_start = 1'b1;
        scale_in = 8'h33;
        pix_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        check("abort2_no_done", fd_pulses - fd0, 0);
        run_pixels(H * V);
        wait_done("abort");
        check("abort_count", corner_count, 8);
        check("abort_ovf", overflow, 1);
        check("abort_scale", scale, 8'h33);
        check("abort_pulses", fd_pulses - fd0, 1);
        set_exp_row(2, 4, 2);
        drain("abort");

`ifdef HARRIS_ROI_EN
        roi_x0 = 10'd3;
        roi_x1 = 10'd4;
        roi_y0 = 9'd2;
        roi_y1 = 9'd2;
        harris_feature = 101;
        start_frame(100, 8'h44);
        run_pixels(H * V);
        wait_done("roi");
        check("roi_count", corner_count, 2);
        check("roi_ovf", overflow, 0);
        set_exp_row(3, 2, 2);
        drain("roi");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
